// File: rtl/scrub_mon_pkg.sv
// Shared types and register map for the bit-flip monitor status poller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scrub_mon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        GAP,
        DONE,
        ABORT
    } poll_state_t;

    localparam int ADDR_INTERR     = 0;
    localparam int ADDR_CXBF       = 1;
    localparam int ADDR_BFD        = 2;
    localparam int NUM_STATUS_REGS = 3;

    // Counter width able to hold 0..n; a disabled (n==0) counter still gets one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n == 0) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/reg_bus.sv
// Simple register bus between an initiator (out) and a target (in).
// Latency: a transfer completes in the cycle where valid and ready are both high.
// Backpressure: target holds ready low to stall; initiator keeps addr stable while valid.
interface REG_BUS #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    write;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    error;
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   rdata;

    modport in  (input  addr, write, wdata, wstrb, valid, output rdata, error, ready);
    modport out (output addr, write, wdata, wstrb, valid, input  rdata, error, ready);
endinterface

// File: rtl/poll_timer.sv
// Modulo-N counter with synchronous clear and count enable; N==0 never expires.
// Latency: expire_o is combinational from the count register (high while count==N-1).
// Backpressure: none; en_i low simply holds the count.
module poll_timer
    import scrub_mon_pkg::*;
#(
    parameter int unsigned N = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int unsigned W = cnt_width(N);
    localparam logic [W-1:0] LAST = (N == 0) ? '0 : W'(N - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise advance and wrap at N-1.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || (N == 0)) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (N != 0) && (cnt_q == LAST);

endmodule

// File: rtl/scrub_monitor_poller.sv
// Polls the bit-flip monitor's three status registers and publishes them as one atomic snapshot.
// Latency: trigger to snap_valid_o is 7 cycles when every read is acked in its first cycle.
// Backpressure: waits on bus ready per read; aborts after TIMEOUT cycles; requests while busy coalesce.
module scrub_monitor_poller
    import scrub_mon_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 2,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned POLL_PERIOD = 1000,
    parameter int unsigned TIMEOUT     = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  trigger_i,
    input  logic                  interr_i,
    REG_BUS.out                   bus_if,
    output logic                  snap_valid_o,
    output logic                  snap_interr_o,
    output logic [DATA_WIDTH-1:0] snap_cxbf_o,
    output logic [DATA_WIDTH-1:0] snap_bfd_o,
    output logic                  busy_o,
    output logic                  timeout_o,
    output logic                  bus_err_o
);
    poll_state_t state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        pending_q, pending_d;
    logic        interr_q;
    logic        snap_valid_q, snap_valid_d;
    logic        timeout_q, timeout_d;
    logic        bus_err_q, bus_err_d;

    logic                  shadow_interr_q;
    logic [DATA_WIDTH-1:0] shadow_cxbf_q, shadow_bfd_q;
    logic                  snap_interr_q;
    logic [DATA_WIDTH-1:0] snap_cxbf_q, snap_bfd_q;

    logic period_exp, to_exp, poll_req, rd_ok;

    poll_timer #(.N(POLL_PERIOD)) u_period (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (!enable_i),
        .en_i     (enable_i && (state_q == IDLE)),
        .expire_o (period_exp)
    );

    poll_timer #(.N(TIMEOUT)) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (state_q != REQ),
        .en_i     (state_q == REQ),
        .expire_o (to_exp)
    );

    assign poll_req = trigger_i | (interr_i & ~interr_q) | (enable_i & period_exp);
    assign rd_ok    = (state_q == REQ) && bus_if.ready && !bus_if.error;

    // Next-state and pulse decode; requests seen outside IDLE fold into one pending flag.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pending_d    = pending_q | (poll_req & (state_q != IDLE));
        snap_valid_d = 1'b0;
        timeout_d    = 1'b0;
        bus_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (poll_req || pending_q) begin
                    state_d   = REQ;
                    pending_d = 1'b0;
                end
            end
            REQ: begin
                if (bus_if.ready) begin
                    if (bus_if.error) begin
                        state_d   = ABORT;
                        bus_err_d = 1'b1;
                    end else if (idx_q == 2'(ADDR_BFD)) begin
                        state_d = DONE;
                    end else begin
                        state_d = GAP;
                    end
                end else if (to_exp) begin
                    state_d   = ABORT;
                    timeout_d = 1'b1;
                end
            end
            GAP: begin
                idx_d   = idx_q + 2'd1;
                state_d = REQ;
            end
            DONE: begin
                snap_valid_d = 1'b1;
                state_d      = IDLE;
            end
            ABORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state, edge detect and registered status pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            interr_q     <= 1'b0;
            snap_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            interr_q     <= interr_i;
            snap_valid_q <= snap_valid_d;
            timeout_q    <= timeout_d;
            bus_err_q    <= bus_err_d;
        end
    end

    // Shadow capture on each good read; snapshot copied only in DONE so it never tears.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_interr_q <= 1'b0;
            shadow_cxbf_q   <= '0;
            shadow_bfd_q    <= '0;
            snap_interr_q   <= 1'b0;
            snap_cxbf_q     <= '0;
            snap_bfd_q      <= '0;
        end else begin
            if (rd_ok && (idx_q == 2'(ADDR_INTERR))) shadow_interr_q <= bus_if.rdata[0];
            if (rd_ok && (idx_q == 2'(ADDR_CXBF)))   shadow_cxbf_q   <= bus_if.rdata;
            if (rd_ok && (idx_q == 2'(ADDR_BFD)))    shadow_bfd_q    <= bus_if.rdata;
            if (state_q == DONE) begin
                snap_interr_q <= shadow_interr_q;
                snap_cxbf_q   <= shadow_cxbf_q;
                snap_bfd_q    <= shadow_bfd_q;
            end
        end
    end

    assign bus_if.valid = (state_q == REQ);
    assign bus_if.addr  = ADDR_WIDTH'(idx_q);
    assign bus_if.write = 1'b0;
    assign bus_if.wdata = '0;
    assign bus_if.wstrb = '0;

    assign snap_valid_o  = snap_valid_q;
    assign snap_interr_o = snap_interr_q;
    assign snap_cxbf_o   = snap_cxbf_q;
    assign snap_bfd_o    = snap_bfd_q;
    assign busy_o        = (state_q != IDLE);
    assign timeout_o     = timeout_q;
    assign bus_err_o     = bus_err_q;

endmodule

// File: tb/tb_scrub_monitor_poller.sv
// Directed bench for the status poller with a configurable register-bus responder.
// Latency: responder acks after resp_delay cycles of valid (0 = same cycle).
// Backpressure: never_rdy holds ready low; err_en answers one address with an error.
module tb_scrub_monitor_poller;

    logic        clk_i = 1'b0;
    logic        rst_i, enable_i, trigger_i, interr_i;
    logic        snap_valid_o, snap_interr_o, busy_o, timeout_o, bus_err_o;
    logic [31:0] snap_cxbf_o, snap_bfd_o;

    REG_BUS #(.ADDR_WIDTH(2), .DATA_WIDTH(32)) bus ();

    scrub_monitor_poller #(
        .ADDR_WIDTH  (2),
        .DATA_WIDTH  (32),
        .POLL_PERIOD (10),
        .TIMEOUT     (8)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .enable_i      (enable_i),
        .trigger_i     (trigger_i),
        .interr_i      (interr_i),
        .bus_if        (bus),
        .snap_valid_o  (snap_valid_o),
        .snap_interr_o (snap_interr_o),
        .snap_cxbf_o   (snap_cxbf_o),
        .snap_bfd_o    (snap_bfd_o),
        .busy_o        (busy_o),
        .timeout_o     (timeout_o),
        .bus_err_o     (bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Responder configuration
    int          resp_delay = 1;
    logic        never_rdy  = 1'b0;
    logic        err_en     = 1'b0;
    logic [1:0]  err_addr   = 2'd1;
    logic [31:0] rd0 = 32'h1, rd1 = 32'h40, rd2 = 32'h7;
    int          vcnt = 0;

    // Responder: ready after resp_delay waiting cycles, rdata by address.
    always_comb begin
        bus.ready = bus.valid && !never_rdy && (vcnt >= resp_delay);
        bus.error = bus.ready && err_en && (bus.addr == err_addr);
        case (bus.addr)
            2'd0:    bus.rdata = rd0;
            2'd1:    bus.rdata = rd1;
            2'd2:    bus.rdata = rd2;
            default: bus.rdata = 32'hDEAD_BEEF;
        endcase
    end

    // Wait-cycle counter for the responder.
    always @(posedge clk_i) begin
        if (!bus.valid || bus.ready) vcnt <= 0;
        else                         vcnt <= vcnt + 1;
    end

    // Bus/status monitor sampled mid-cycle.
    int   hs_cnt = 0, rise_cnt = 0, vhigh_cnt = 0, snap_cnt = 0, to_cnt = 0, be_cnt = 0;
    int   hs_addr [256];
    logic valid_prev = 1'b0;
    always @(negedge clk_i) begin
        if (bus.valid && bus.ready) begin
            hs_addr[hs_cnt % 256] <= int'(bus.addr);
            hs_cnt <= hs_cnt + 1;
        end
        if (bus.valid && !valid_prev) rise_cnt <= rise_cnt + 1;
        if (bus.valid)    vhigh_cnt <= vhigh_cnt + 1;
        if (snap_valid_o) snap_cnt  <= snap_cnt + 1;
        if (timeout_o)    to_cnt    <= to_cnt + 1;
        if (bus_err_o)    be_cnt    <= be_cnt + 1;
        valid_prev <= bus.valid;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_trigger();
        trigger_i = 1'b1;
        tick();
        trigger_i = 1'b0;
    endtask

    task automatic wait_snap(input string tag, input int bound);
        int n = 0;
        while (!snap_valid_o && n < bound) begin
            tick();
            n++;
        end
        check(tag, 32'(snap_valid_o), 32'd1);
    endtask

    // Ticks until a new poll begins (valid rises at addr 0); n = ticks taken.
    task automatic wait_start(input int bound, output int n, output logic found);
        logic prev;
        n     = 0;
        found = 1'b0;
        prev  = bus.valid;
        while (!found && n < bound) begin
            tick();
            n++;
            if (bus.valid && !prev && bus.addr == 2'd0) found = 1'b1;
            prev = bus.valid;
        end
    endtask

    int   b_hs, b_rise, b_vh, b_snap, b_to, b_be, n;
    logic found;

    initial begin
        rst_i     = 1'b1;
        enable_i  = 1'b0;
        trigger_i = 1'b0;
        interr_i  = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_valid",      32'(bus.valid),     32'd0);
        check("rst_addr",       32'(bus.addr),      32'd0);
        check("rst_busy",       32'(busy_o),        32'd0);
        check("rst_snap_valid", 32'(snap_valid_o),  32'd0);
        check("rst_snap_int",   32'(snap_interr_o), 32'd0);
        check("rst_snap_cxbf",  snap_cxbf_o,        32'd0);
        check("rst_snap_bfd",   snap_bfd_o,         32'd0);
        check("rst_timeout",    32'(timeout_o),     32'd0);
        check("rst_bus_err",    32'(bus_err_o),     32'd0);
        rst_i = 1'b0;
        repeat (2) tick();

        // Basic poll, reads acked on their second cycle
        b_hs = hs_cnt; b_rise = rise_cnt; b_snap = snap_cnt;
        pulse_trigger();
        wait_snap("basic_snap_pulse", 60);
        check("basic_interr", 32'(snap_interr_o), 32'd1);
        check("basic_cxbf",   snap_cxbf_o,        32'h40);
        check("basic_bfd",    snap_bfd_o,         32'h7);
        check("basic_write",  32'(bus.write),     32'd0);
        check("basic_wstrb",  32'(bus.wstrb),     32'd0);
        repeat (3) tick();
        check("basic_reads",      32'(hs_cnt - b_hs),     32'd3);
        check("basic_valid_gaps", 32'(rise_cnt - b_rise), 32'd3);
        check("basic_snap_count", 32'(snap_cnt - b_snap), 32'd1);
        check("basic_addr0", 32'(hs_addr[(b_hs + 0) % 256]), 32'd0);
        check("basic_addr1", 32'(hs_addr[(b_hs + 1) % 256]), 32'd1);
        check("basic_addr2", 32'(hs_addr[(b_hs + 2) % 256]), 32'd2);

        // Latency with immediate ack; only rdata[0] of addr 0 is used
        resp_delay = 0;
        rd0 = 32'hFFFF_FFFE; rd1 = 32'h123; rd2 = 32'h55;
        trigger_i = 1'b1;
        tick();
        trigger_i = 1'b0;
        repeat (5) tick();
        check("lat_t6_quiet", 32'(snap_valid_o), 32'd0);
        tick();
        check("lat_t7_pulse", 32'(snap_valid_o),  32'd1);
        check("lat_interr",   32'(snap_interr_o), 32'd0);
        check("lat_cxbf",     snap_cxbf_o,        32'h123);
        check("lat_bfd",      snap_bfd_o,         32'h55);
        repeat (3) tick();

        // Timeout: target never ready
        never_rdy = 1'b1;
        b_vh = vhigh_cnt; b_to = to_cnt; b_snap = snap_cnt;
        pulse_trigger();
        n = 0;
        while (!timeout_o && n < 40) begin tick(); n++; end
        check("to_pulse", 32'(timeout_o), 32'd1);
        tick();
        check("to_busy_after", 32'(busy_o), 32'd0);
        repeat (2) tick();
        check("to_valid_cycles", 32'(vhigh_cnt - b_vh), 32'd8);
        check("to_pulse_count",  32'(to_cnt - b_to),    32'd1);
        check("to_no_snap",      32'(snap_cnt - b_snap), 32'd0);
        check("to_cxbf_kept",    snap_cxbf_o,           32'h123);
        check("to_bfd_kept",     snap_bfd_o,            32'h55);
        never_rdy = 1'b0;

        // Bus error on addr 1
        err_en = 1'b1; err_addr = 2'd1;
        b_snap = snap_cnt; b_be = be_cnt;
        pulse_trigger();
        n = 0;
        while (!bus_err_o && n < 40) begin tick(); n++; end
        check("be_pulse", 32'(bus_err_o), 32'd1);
        tick();
        check("be_idle", 32'(busy_o), 32'd0);
        repeat (4) tick();
        check("be_pulse_count", 32'(be_cnt - b_be),     32'd1);
        check("be_no_snap",     32'(snap_cnt - b_snap), 32'd0);
        check("be_bfd_kept",    snap_bfd_o,             32'h55);
        err_en = 1'b0;

        // Coalescing: 3 triggers plus an interr edge during one poll
        resp_delay = 1;
        rd0 = 32'h1; rd1 = 32'h40; rd2 = 32'h7;
        b_snap = snap_cnt; b_rise = rise_cnt; b_hs = hs_cnt;
        pulse_trigger();
        tick();
        pulse_trigger();
        tick();
        pulse_trigger();
        interr_i = 1'b1;
        tick();
        pulse_trigger();
        repeat (40) tick();
        check("coal_snaps", 32'(snap_cnt - b_snap), 32'd2);
        check("coal_reads", 32'(hs_cnt - b_hs),     32'd6);
        check("coal_rises", 32'(rise_cnt - b_rise), 32'd6);
        interr_i = 1'b0;
        repeat (20) tick();
        check("coal_fall_no_poll", 32'(snap_cnt - b_snap), 32'd2);

        // Periodic polling, POLL_PERIOD=10, immediate ack
        resp_delay = 0;
        enable_i = 1'b1;
        wait_start(40, n, found);
        check("per_first_found", 32'(found), 32'd1);
        check("per_first_delay", 32'(n),     32'd10);
        wait_start(40, n, found);
        check("per_interval1", 32'(n), 32'd16);
        wait_start(40, n, found);
        check("per_interval2", 32'(n), 32'd16);
        enable_i = 1'b0;
        repeat (10) tick();
        b_rise = rise_cnt; b_snap = snap_cnt;
        repeat (60) tick();
        check("per_off_rises", 32'(rise_cnt - b_rise), 32'd0);
        check("per_off_snaps", 32'(snap_cnt - b_snap), 32'd0);

        // Reset in the middle of the addr-1 read
        resp_delay = 1;
        pulse_trigger();
        n = 0;
        while (!(bus.valid && bus.addr == 2'd1) && n < 30) begin tick(); n++; end
        check("mid_reached_addr1", 32'(bus.valid && bus.addr == 2'd1), 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check("mid_valid",      32'(bus.valid),     32'd0);
        check("mid_addr",       32'(bus.addr),      32'd0);
        check("mid_busy",       32'(busy_o),        32'd0);
        check("mid_snap_int",   32'(snap_interr_o), 32'd0);
        check("mid_snap_cxbf",  snap_cxbf_o,        32'd0);
        check("mid_snap_bfd",   snap_bfd_o,         32'd0);
        check("mid_snap_valid", 32'(snap_valid_o),  32'd0);
        tick();
        rst_i = 1'b0;
        repeat (2) tick();
        b_hs = hs_cnt;
        pulse_trigger();
        wait_snap("post_rst_snap", 60);
        repeat (2) tick();
        check("post_rst_addr0", 32'(hs_addr[b_hs % 256]), 32'd0);
        check("post_rst_cxbf",  snap_cxbf_o,             32'h40);
        check("post_rst_bfd",   snap_bfd_o,              32'h7);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
